bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the shared 16-bit-address / 256-bit-data system bus.
- Master 0 is the execution engine. Master 1 is the host/program loader.
- Grants the bus round-robin, drives one master's address, strobes and write data onto the bus, and decodes the address region into one-hot slave selects.
- Routes the selected slave's read data back to the granted master. Sits between the masters and instruction memory, main memory, the matrix ALU and the integer ALU.

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 256, bus data width
- MAX_HOLD, 32, grant cycles after which a holder may be preempted

Ports:
- Clk  in  1  system clock, rising edge
- nReset  in  1  reset, synchronous, active-low
- req0  in  1  master 0 bus request
- gnt0  out  1  master 0 grant
- addr0  in  ADDR_W  master 0 address
- nRead0  in  1  master 0 read strobe, active-low
- nWrite0  in  1  master 0 write strobe, active-low
- wdata0  in  DATA_W  master 0 write data
- rdata0  out  DATA_W  read data returned to master 0
- req1, gnt1, addr1, nRead1, nWrite1, wdata1, rdata1: same as master 0, for master 1
- address  out  ADDR_W  shared bus address
- nRead  out  1  shared bus read strobe
- nWrite  out  1  shared bus write strobe
- BusDataOut  out  DATA_W  shared bus write data
- sel  out  4  one-hot slave select: [0] main mem, [1] int ALU, [2] matrix ALU, [3] instr mem
- InstructDataOut  in  DATA_W  instruction memory read data
- MemDataOut  in  DATA_W  main memory read data
- MatrixDataOut  in  DATA_W  matrix ALU read data
- IntDataOut  in  DATA_W  integer ALU read data
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (nReset=0 at a Clk edge) sets: gnt0=gnt1=0, address=0, nRead=nWrite=1, BusDataOut=0, sel=0, err=0, state IDLE, hold counter 0, last-granted pointer = 1 (so master 0 wins the first tie).
- Reset mid-transaction abandons the transfer; all outputs take reset values at that edge.
- States:
  - IDLE: no grant, bus idle.
  - GRANT0 / GRANT1: master n owns the bus.
  - TURN: one-cycle dead cycle on handover.
- IDLE transition: any req sampled high -> GRANTn on the next edge. gnt asserts one cycle after req is first sampled. If both req are high, the master other than last-granted wins, and the pointer updates.
- GRANTn outputs:
  - address, nRead, nWrite and BusDataOut are registered copies of master n's inputs (1-cycle latency).
  - The non-granted master's inputs are ignored entirely.
- Region decode uses address[15:12]:
  - 4'h0 -> sel=0001
  - 4'h3 -> sel=0010
  - 4'h2 -> sel=0100
  - 4'h8 -> sel=1000
  - any other value -> sel=0000
  - sel is registered alongside address.
- Read-data return:
  - rdata_n is a combinational mux of the slave data chosen by the registered sel, and only when gnt_n=1.
  - It is 0 when the master is not granted or sel=0.
  - A slave's fixed 2-cycle read latency is preserved end to end, plus the 1 registered cycle.
- Normal release: req_n low in GRANTn -> TURN.
- Preemption:
  - The hold counter increments each GRANT cycle and saturates at MAX_HOLD.
  - If count >= MAX_HOLD, the other req is high, and master n's nRead_n=nWrite_n=1 (idle cycle), then -> TURN.
  - A master is never cut off mid-strobe.
- TURN:
  - gnt0=gnt1=0, nRead=nWrite=1, BusDataOut=0, sel=0, address holds its last value, hold counter clears.
  - Next state uses the IDLE arbitration rule, so a preempted master that still requests loses to the waiting one.
- Protocol error: if the granted master drives nRead and nWrite low together, the bus drives both high that cycle and err sets. err stays set until reset.
- The same req dropping while the other req rises in the same cycle goes through TURN; there is never a direct GRANT0<->GRANT1 transition.

Decomposition:
- bus_pkg holds:
  - ADDR_W/DATA_W defaults
  - region nibble constants REG_MEM=4'h0, REG_INT=4'h3, REG_MAT=4'h2, REG_INS=4'h8
  - the sel bit indices
  - the enum arb_state_t {IDLE, GRANT0, GRANT1, TURN}
- Sub-module bus_addr_decode (combinational): address[15:12] -> one-hot sel. It is reused by the read-data mux.

Test Plan:
- Reset, then req0=1 alone: gnt0=1 after 1 cycle; addr0=16'h8003 with nRead0=0 -> next cycle address=8003, sel=1000; rdata0 = InstructDataOut.
- req0 and req1 rise in the same cycle after reset -> gnt0 first. Drop req0 -> TURN with nRead=nWrite=1, then gnt1=1.
- Master 1 holds with MAX_HOLD=4 while req0 is high and nWrite1 pulses low every other cycle -> TURN occurs only in a cycle with nRead1=nWrite1=1 and count>=4, then gnt0=1.
- Granted master writes addr=16'h2011, wdata=256'h55 -> sel=0100, BusDataOut=55, nWrite=0. Same write from the ungranted master -> bus unchanged.
- Granted master drives nRead=nWrite=0 -> bus strobes both high and err=1, staying high until nReset=0 clears it; addr=16'h5000 gives sel=0 and rdata=0.
- nReset=0 in the middle of a GRANT1 write -> at that edge gnt1=0, nWrite=1, BusDataOut=0; after release, req1 alone is granted again.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, region map and arbiter state type for the system bus
package bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 256;

  // Address region nibbles, taken from address[15:12]
  localparam logic [3:0] REG_MEM = 4'h0;
  localparam logic [3:0] REG_INT = 4'h3;
  localparam logic [3:0] REG_MAT = 4'h2;
  localparam logic [3:0] REG_INS = 4'h8;

  // Bit positions inside the one-hot slave select
  localparam int SEL_MEM = 0;
  localparam int SEL_INT = 1;
  localparam int SEL_MAT = 2;
  localparam int SEL_INS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TURN   = 2'd3
  } arb_state_t;

  function automatic logic [3:0] region_to_sel(input logic [3:0] region);
    logic [3:0] s;
    s = '0;
    case (region)
      REG_MEM: s[SEL_MEM] = 1'b1;
      REG_INT: s[SEL_INT] = 1'b1;
      REG_MAT: s[SEL_MAT] = 1'b1;
      REG_INS: s[SEL_INS] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master bus bundle with arbiter-side and environment-side views
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              gnt0;
  logic [ADDR_W-1:0] addr0;
  logic              nRead0;
  logic              nWrite0;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              gnt1;
  logic [ADDR_W-1:0] addr1;
  logic              nRead1;
  logic              nWrite1;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] address;
  logic              nRead;
  logic              nWrite;
  logic [DATA_W-1:0] BusDataOut;
  logic [3:0]        sel;

  logic [DATA_W-1:0] InstructDataOut;
  logic [DATA_W-1:0] MemDataOut;
  logic [DATA_W-1:0] MatrixDataOut;
  logic [DATA_W-1:0] IntDataOut;

  logic              err;

  // The arbiter masters the shared bus, so it takes the master view
  modport master (
    input  req0, addr0, nRead0, nWrite0, wdata0,
    input  req1, addr1, nRead1, nWrite1, wdata1,
    input  InstructDataOut, MemDataOut, MatrixDataOut, IntDataOut,
    output gnt0, rdata0, gnt1, rdata1,
    output address, nRead, nWrite, BusDataOut, sel, err
  );

  modport slave (
    output req0, addr0, nRead0, nWrite0, wdata0,
    output req1, addr1, nRead1, nWrite1, wdata1,
    output InstructDataOut, MemDataOut, MatrixDataOut, IntDataOut,
    input  gnt0, rdata0, gnt1, rdata1,
    input  address, nRead, nWrite, BusDataOut, sel, err
  );

endinterface

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - address region nibble to one-hot slave select
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [3:0] region,
  output logic [3:0] sel
);

  always_comb begin
    sel = region_to_sel(region);
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin two-master arbiter with registered bus drive,
// region decode, read-data return and bounded hold preemption
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 32
)(
  input  logic          Clk,
  input  logic          nReset,
  bus_arbiter_if.master bus
);

  localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  arb_state_t        state;
  arb_state_t        next_state;
  logic              last;
  logic [CNT_W-1:0]  hold_cnt;
  logic              err_q;

  logic              arb_any;
  logic              arb_pick;
  logic              hold_full;
  logic              preempt0;
  logic              preempt1;

  logic              gnt0_c;
  logic              gnt1_c;
  logic              keep;
  logic              proto_err;
  logic [ADDR_W-1:0] m_addr;
  logic              m_nread;
  logic              m_nwrite;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        dec_sel;

  logic [ADDR_W-1:0] addr_d,   addr_q;
  logic              nread_d,  nread_q;
  logic              nwrite_d, nwrite_q;
  logic [DATA_W-1:0] data_d,   data_q;
  logic [3:0]        sel_d,    sel_q;
  logic [DATA_W-1:0] rd_mux;

  // Tie goes to the master that was not granted last
  assign arb_any   = bus.req0 | bus.req1;
  assign arb_pick  = (bus.req0 & bus.req1) ? ~last : bus.req1;
  assign hold_full = (hold_cnt >= HOLD_MAX);
  assign preempt0  = hold_full & bus.req1 & bus.nRead0 & bus.nWrite0;
  assign preempt1  = hold_full & bus.req0 & bus.nRead1 & bus.nWrite1;

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE || state == TURN) && arb_any)
        last <= arb_pick;
      if (state == GRANT0 || state == GRANT1) begin
        if (hold_cnt != HOLD_MAX)
          hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (proto_err)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, TURN: begin
        if (arb_any)
          next_state = arb_pick ? GRANT1 : GRANT0;
        else
          next_state = IDLE;
      end
      GRANT0:  if (!bus.req0 || preempt0) next_state = TURN;
      GRANT1:  if (!bus.req1 || preempt1) next_state = TURN;
      default: next_state = IDLE;
    endcase
  end

  bus_addr_decode u_decode (
    .region (m_addr[ADDR_W-1 -: 4]),
    .sel    (dec_sel)
  );

  // Only the granted master's inputs reach the bus; leaving a grant idles it
  always_comb begin
    gnt0_c    = (state == GRANT0);
    gnt1_c    = (state == GRANT1);
    m_addr    = gnt1_c ? bus.addr1   : bus.addr0;
    m_nread   = gnt1_c ? bus.nRead1  : bus.nRead0;
    m_nwrite  = gnt1_c ? bus.nWrite1 : bus.nWrite0;
    m_wdata   = gnt1_c ? bus.wdata1  : bus.wdata0;
    keep      = (gnt0_c && next_state == GRANT0) || (gnt1_c && next_state == GRANT1);
    proto_err = (gnt0_c | gnt1_c) & ~m_nread & ~m_nwrite;
    addr_d    = addr_q;
    nread_d   = 1'b1;
    nwrite_d  = 1'b1;
    data_d    = '0;
    sel_d     = '0;
    if (keep) begin
      addr_d   = m_addr;
      data_d   = m_wdata;
      sel_d    = dec_sel;
      nread_d  = m_nread  | proto_err;
      nwrite_d = m_nwrite | proto_err;
    end
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      addr_q   <= '0;
      nread_q  <= 1'b1;
      nwrite_q <= 1'b1;
      data_q   <= '0;
      sel_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      nread_q  <= nread_d;
      nwrite_q <= nwrite_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_q[SEL_MEM])      rd_mux = bus.MemDataOut;
    else if (sel_q[SEL_INT]) rd_mux = bus.IntDataOut;
    else if (sel_q[SEL_MAT]) rd_mux = bus.MatrixDataOut;
    else if (sel_q[SEL_INS]) rd_mux = bus.InstructDataOut;
  end

  assign bus.gnt0       = gnt0_c;
  assign bus.gnt1       = gnt1_c;
  assign bus.rdata0     = gnt0_c ? rd_mux : '0;
  assign bus.rdata1     = gnt1_c ? rd_mux : '0;
  assign bus.address    = addr_q;
  assign bus.nRead      = nread_q;
  assign bus.nWrite     = nwrite_q;
  assign bus.BusDataOut = data_q;
  assign bus.sel        = sel_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  localparam logic [255:0] D_INS = {8{32'hA1A1_0008}};
  localparam logic [255:0] D_MEM = {8{32'hB2B2_0000}};
  localparam logic [255:0] D_MAT = {8{32'hC3C3_0002}};
  localparam logic [255:0] D_INT = {8{32'hD4D4_0003}};

  typedef struct {
    string        tag;
    logic [255:0] exp;
  } exp_t;

  logic Clk;
  logic nReset;
  int   total;
  int   bad;
  exp_t sb[$];

  bus_arbiter_if #(.ADDR_W(16), .DATA_W(256)) bif ();

  bus_arbiter #(.ADDR_W(16), .DATA_W(256), .MAX_HOLD(4)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bif.master)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [255:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [255:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nReset = 1'b0;
    bif.req0 = 0; bif.addr0 = '0; bif.nRead0 = 1; bif.nWrite0 = 1; bif.wdata0 = '0;
    bif.req1 = 0; bif.addr1 = '0; bif.nRead1 = 1; bif.nWrite1 = 1; bif.wdata1 = '0;
    bif.InstructDataOut = D_INS;
    bif.MemDataOut      = D_MEM;
    bif.MatrixDataOut   = D_MAT;
    bif.IntDataOut      = D_INT;

    // Reset state
    push("rst_gnt0", 0); push("rst_gnt1", 0); push("rst_addr", 0); push("rst_nread", 1);
    push("rst_nwrite", 1); push("rst_data", 0); push("rst_sel", 0); push("rst_err", 0);
    tick(); tick();
    pop_check(bif.gnt0); pop_check(bif.gnt1); pop_check(bif.address); pop_check(bif.nRead);
    pop_check(bif.nWrite); pop_check(bif.BusDataOut); pop_check(bif.sel); pop_check(bif.err);

    // Master 0 alone: grant after one cycle, then instruction-memory read
    nReset = 1; bif.req0 = 1;
    push("t1_gnt0", 1); push("t1_gnt1", 0);
    tick();
    pop_check(bif.gnt0); pop_check(bif.gnt1);
    bif.addr0 = 16'h8003; bif.nRead0 = 0;
    push("t1_addr", 16'h8003); push("t1_sel", 4'b1000); push("t1_nread", 0); push("t1_rdata0", D_INS);
    push("t1_rdata1", 0);
    tick();
    pop_check(bif.address); pop_check(bif.sel); pop_check(bif.nRead); pop_check(bif.rdata0);
    pop_check(bif.rdata1);
    bif.nRead0 = 1; bif.req0 = 0;
    push("t1_rel_gnt0", 0); push("t1_rel_sel", 0); push("t1_rel_addr_hold", 16'h8003); push("t1_rel_rdata0", 0);
    tick();
    pop_check(bif.gnt0); pop_check(bif.sel); pop_check(bif.address); pop_check(bif.rdata0);
    tick();

    // Simultaneous requests after reset: master 0 first, handover through TURN
    nReset = 0; tick(); nReset = 1;
    bif.req0 = 1; bif.req1 = 1;
    push("t2_gnt0", 1); push("t2_gnt1", 0);
    tick();
    pop_check(bif.gnt0); pop_check(bif.gnt1);
    tick();
    bif.req0 = 0;
    push("t2_turn_gnt0", 0); push("t2_turn_gnt1", 0); push("t2_turn_nread", 1); push("t2_turn_nwrite", 1);
    tick();
    pop_check(bif.gnt0); pop_check(bif.gnt1); pop_check(bif.nRead); pop_check(bif.nWrite);
    push("t2_gnt1_after", 1); push("t2_gnt0_after", 0);
    tick();
    pop_check(bif.gnt1); pop_check(bif.gnt0);

    // Preemption of master 1 only in an idle cycle once the hold limit is reached
    bif.req0 = 1; bif.addr1 = 16'h0010;
    for (int k = 0; k < 6; k++) begin
      bif.nWrite1 = (k % 2 == 0) ? 1'b0 : 1'b1;
      push($sformatf("t3_gnt1_k%0d", k), (k < 5) ? 1 : 0);
      push($sformatf("t3_nwrite_k%0d", k), (k % 2 == 0 && k < 5) ? 0 : 1);
      tick();
      pop_check(bif.gnt1); pop_check(bif.nWrite);
    end
    bif.nWrite1 = 1;
    push("t3_gnt0_after", 1); push("t3_gnt1_after", 0);
    tick();
    pop_check(bif.gnt0); pop_check(bif.gnt1);

    // Granted write to the matrix ALU, then an ignored write from the ungranted master
    bif.addr0 = 16'h2011; bif.wdata0 = 256'h55; bif.nWrite0 = 0;
    push("t4_sel", 4'b0100); push("t4_data", 256'h55); push("t4_nwrite", 0); push("t4_addr", 16'h2011);
    push("t4_rdata0", D_MAT);
    tick();
    pop_check(bif.sel); pop_check(bif.BusDataOut); pop_check(bif.nWrite); pop_check(bif.address);
    pop_check(bif.rdata0);
    bif.req1 = 0; bif.addr0 = 16'h3000; bif.wdata0 = '0; bif.nWrite0 = 1;
    bif.addr1 = 16'h2011; bif.wdata1 = 256'h55; bif.nWrite1 = 0;
    push("t4_ign_addr", 16'h3000); push("t4_ign_sel", 4'b0010); push("t4_ign_data", 0);
    push("t4_ign_nwrite", 1); push("t4_ign_rdata1", 0); push("t4_ign_rdata0", D_INT);
    tick();
    pop_check(bif.address); pop_check(bif.sel); pop_check(bif.BusDataOut);
    pop_check(bif.nWrite); pop_check(bif.rdata1); pop_check(bif.rdata0);

    // Protocol error on an unmapped region; err is sticky until reset
    bif.nWrite1 = 1;
    bif.addr0 = 16'h5000; bif.nRead0 = 0; bif.nWrite0 = 0;
    push("t5_err", 1); push("t5_nread", 1); push("t5_nwrite", 1); push("t5_sel", 0); push("t5_rdata0", 0);
    tick();
    pop_check(bif.err); pop_check(bif.nRead); pop_check(bif.nWrite); pop_check(bif.sel); pop_check(bif.rdata0);
    bif.nRead0 = 1; bif.nWrite0 = 1;
    push("t5_err_hold", 1);
    tick();
    pop_check(bif.err);
    bif.req0 = 0;
    tick(); tick();
    push("t5_err_idle", 1);
    pop_check(bif.err);
    nReset = 0;
    push("t5_err_clr", 0);
    tick();
    pop_check(bif.err);
    nReset = 1;

    // Reset in the middle of a master 1 write
    bif.req1 = 1;
    push("t6_gnt1", 1);
    tick();
    pop_check(bif.gnt1);
    bif.addr1 = 16'h0040; bif.wdata1 = 256'hABCD; bif.nWrite1 = 0;
    push("t6_nwrite", 0); push("t6_data", 256'hABCD); push("t6_sel", 4'b0001); push("t6_rdata1", D_MEM);
    tick();
    pop_check(bif.nWrite); pop_check(bif.BusDataOut); pop_check(bif.sel); pop_check(bif.rdata1);
    nReset = 0;
    push("t6_rst_gnt1", 0); push("t6_rst_nwrite", 1); push("t6_rst_data", 0); push("t6_rst_sel", 0);
    push("t6_rst_addr", 0);
    tick();
    pop_check(bif.gnt1); pop_check(bif.nWrite); pop_check(bif.BusDataOut); pop_check(bif.sel);
    pop_check(bif.address);
    nReset = 1;
    push("t6_regrant", 1);
    tick();
    pop_check(bif.gnt1);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
